// File: rtl/izh_param_loader.sv
// Byte-serial, checksummed configuration front end for izh_neuron_lite.
// Parameter and stimulus frames are shadowed and committed atomically on a good checksum.
module izh_param_loader #(
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] HDR_PARAM = 8'hA5,
  parameter logic [7:0] HDR_STIM  = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] param_a,
  output logic [7:0] param_b,
  output logic [7:0] param_c,
  output logic [7:0] param_d,
  output logic       params_ready,
  output logic [7:0] stimulus_out,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, P_A, P_B, P_C, P_D, P_CHK, S_VAL, S_CHK
  } state_t;

  // Handshake: byte_in is consumed on every rising clk edge where byte_valid is high;
  // there is no back-pressure, the loader accepts one byte per cycle in every state.

  state_t        state, state_nxt;
  logic [CW-1:0] tcnt;
  logic [7:0]    acc;
  logic [7:0]    sh_a, sh_b, sh_c, sh_d, sh_s;
  logic          timeout_hit;
  logic          chk_ok;

  // A byte on the cycle the counter would reach TIMEOUT wins over the abort.
  assign timeout_hit = (state != IDLE) && !byte_valid && (tcnt == CW'(TIMEOUT - 1));
  assign chk_ok      = ((acc ^ byte_in) == 8'h00);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else if (byte_valid) begin
      unique case (state)
        IDLE: begin
          if (byte_in == HDR_PARAM)     state_nxt = P_A;
          else if (byte_in == HDR_STIM) state_nxt = S_VAL;
        end
        P_A:     state_nxt = P_B;
        P_B:     state_nxt = P_C;
        P_C:     state_nxt = P_D;
        P_D:     state_nxt = P_CHK;
        P_CHK:   state_nxt = IDLE;
        S_VAL:   state_nxt = S_CHK;
        S_CHK:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt         <= '0;
      acc          <= 8'h00;
      sh_a         <= 8'h00;
      sh_b         <= 8'h00;
      sh_c         <= 8'h00;
      sh_d         <= 8'h00;
      sh_s         <= 8'h00;
      param_a      <= 8'h00;
      param_b      <= 8'h00;
      param_c      <= 8'h00;
      param_d      <= 8'h00;
      params_ready <= 1'b0;
      stimulus_out <= 8'h00;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_hit) begin
        frame_err <= 1'b1;
        tcnt      <= '0;
        acc       <= 8'h00;
        sh_a      <= 8'h00;
        sh_b      <= 8'h00;
        sh_c      <= 8'h00;
        sh_d      <= 8'h00;
        sh_s      <= 8'h00;
      end else if (state == IDLE) begin
        tcnt <= '0;
        if (byte_valid) acc <= byte_in;
      end else if (byte_valid) begin
        tcnt <= '0;
        acc  <= acc ^ byte_in;
        unique case (state)
          P_A:   sh_a <= byte_in;
          P_B:   sh_b <= byte_in;
          P_C:   sh_c <= byte_in;
          P_D:   sh_d <= byte_in;
          S_VAL: sh_s <= byte_in;
          P_CHK: begin
            if (chk_ok) begin
              param_a      <= sh_a;
              param_b      <= sh_b;
              param_c      <= sh_c;
              param_d      <= sh_d;
              params_ready <= 1'b1;
              frame_ok     <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          S_CHK: begin
            if (chk_ok) begin
              stimulus_out <= sh_s;
              frame_ok     <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        tcnt <= tcnt + CW'(1);
      end
    end
  end

endmodule
